quad_debounce: RTL and testbench

Two-channel synchronizer and debouncer for the raw quadrature pins of a mechanical rotary encoder. It sits directly upstream of the quadrature decoder and drives that decoder's `a`/`b` inputs with metastability-safe, bounce-free levels. It also emits one-cycle change strobes and can optionally count rejected glitches for board bring-up.

---
 rtl/encoder_pkg.sv | 13 +
 rtl/debounce_channel.sv | 59 +++++
 rtl/quad_debounce.sv | 73 +++++++
 tb/tb_quad_debounce.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared defaults for the rotary-encoder front end (debouncer and decoder).
package encoder_pkg;

    localparam int DEBOUNCE_SYNC_STAGES   = 2;
    localparam int DEBOUNCE_STABLE_CYCLES = 255;
    localparam int GLITCH_WIDTH           = 8;

    // Minimal width that can hold n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One encoder pin: synchronizer chain, stability counter, debounced level,
// change strobe and a combinational glitch pulse for the top-level accumulator.
module debounce_channel
    import encoder_pkg::*;
#(
    parameter int SYNC_STAGES   = DEBOUNCE_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEBOUNCE_STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_changed,
    output logic o_glitch
);

    localparam int CNT_W = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_changed;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_changed <= 1'b0;
        end else if (w_s == r_level) begin
            r_cnt     <= '0;
            r_changed <= 1'b0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt     <= '0;
            r_level   <= w_s;
            r_changed <= 1'b1;
        end else begin
            r_cnt     <= r_cnt + CNT_W'(1);
            r_changed <= 1'b0;
        end
    end

    // A partially counted level that falls back is a rejected transition.
    assign o_glitch  = (w_s == r_level) && (r_cnt != '0);
    assign o_level   = r_level;
    assign o_changed = r_changed;

endmodule

// File: rtl/quad_debounce.sv
// Two-channel quadrature pin debouncer. QUAD_DEBOUNCE_GLITCH_CNT_EN builds the
// saturating rejected-glitch counter; otherwise glitch_count is tied to 0.
module quad_debounce #(
    parameter int SYNC_STAGES   = encoder_pkg::DEBOUNCE_SYNC_STAGES,
    parameter int STABLE_CYCLES = encoder_pkg::DEBOUNCE_STABLE_CYCLES,
    parameter int GLITCH_WIDTH  = encoder_pkg::GLITCH_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_raw,
    input  logic                    b_raw,
    output logic                    a,
    output logic                    b,
    output logic                    a_changed,
    output logic                    b_changed,
    output logic [GLITCH_WIDTH-1:0] glitch_count
);

    logic w_glitch_a;
    logic w_glitch_b;

    debounce_channel #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_chan_a (
        .clk       (clk),
        .reset     (reset),
        .i_raw     (a_raw),
        .o_level   (a),
        .o_changed (a_changed),
        .o_glitch  (w_glitch_a)
    );

    debounce_channel #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_chan_b (
        .clk       (clk),
        .reset     (reset),
        .i_raw     (b_raw),
        .o_level   (b),
        .o_changed (b_changed),
        .o_glitch  (w_glitch_b)
    );

`ifdef QUAD_DEBOUNCE_GLITCH_CNT_EN
    logic [GLITCH_WIDTH-1:0] r_glitch_count;
    logic [1:0]              w_inc;
    logic [GLITCH_WIDTH:0]   w_sum;

    assign w_inc = {1'b0, w_glitch_a} + {1'b0, w_glitch_b};
    // One spare bit catches overflow; +2 can never exceed it.
    assign w_sum = {1'b0, r_glitch_count} + {{(GLITCH_WIDTH-1){1'b0}}, w_inc};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_glitch_count <= '0;
        end else if (w_sum[GLITCH_WIDTH]) begin
            r_glitch_count <= '1;
        end else begin
            r_glitch_count <= w_sum[GLITCH_WIDTH-1:0];
        end
    end

    assign glitch_count = r_glitch_count;
`else
    logic w_glitch_unused;

    assign w_glitch_unused = w_glitch_a ^ w_glitch_b;
    assign glitch_count    = '0;
`endif

endmodule

// File: tb/tb_quad_debounce.sv
// Directed bench for quad_debounce (SYNC_STAGES=2, STABLE_CYCLES=4, GLITCH_WIDTH=2);
// glitch expectations follow QUAD_DEBOUNCE_GLITCH_CNT_EN.
module tb_quad_debounce;

    localparam int SS  = 2;
    localparam int SC  = 4;
    localparam int GW  = 2;
    localparam int LAT = SS + SC;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_raw;
    logic          b_raw;
    logic          a;
    logic          b;
    logic          a_changed;
    logic          b_changed;
    logic [GW-1:0] glitch_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    quad_debounce #(
        .SYNC_STAGES   (SS),
        .STABLE_CYCLES (SC),
        .GLITCH_WIDTH  (GW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .a_raw        (a_raw),
        .b_raw        (b_raw),
        .a            (a),
        .b            (b),
        .a_changed    (a_changed),
        .b_changed    (b_changed),
        .glitch_count (glitch_count)
    );

    function automatic int gx(input int n);
`ifdef QUAD_DEBOUNCE_GLITCH_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Raw levels were just changed; outputs must hold pa/pb until edge LAT.
    task automatic lat_check(input string tag, input logic pa, input logic pb,
                             input logic na, input logic nb);
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k < LAT) begin
                chk({tag, "_a_early"}, 32'(a), 32'(pa));
                chk({tag, "_b_early"}, 32'(b), 32'(pb));
                chk({tag, "_ach_early"}, 32'(a_changed), 32'd0);
                chk({tag, "_bch_early"}, 32'(b_changed), 32'd0);
            end else begin
                chk({tag, "_a"}, 32'(a), 32'(na));
                chk({tag, "_b"}, 32'(b), 32'(nb));
                chk({tag, "_ach"}, 32'(a_changed), 32'(na != pa));
                chk({tag, "_bch"}, 32'(b_changed), 32'(nb != pb));
            end
        end
        tick();
        chk({tag, "_ach_after"}, 32'(a_changed), 32'd0);
        chk({tag, "_bch_after"}, 32'(b_changed), 32'd0);
    endtask

    initial begin
        // Reset held with both pins high.
        reset = 1'b1;
        a_raw = 1'b1;
        b_raw = 1'b1;
        repeat (3) tick();
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_b", 32'(b), 32'd0);
        chk("rst_ach", 32'(a_changed), 32'd0);
        chk("rst_bch", 32'(b_changed), 32'd0);
        chk("rst_glitch", 32'(glitch_count), 32'd0);
        reset = 1'b0;
        lat_check("rel", 1'b0, 1'b0, 1'b1, 1'b1);

        // Clean edges on A only: fall then rise.
        a_raw = 1'b0;
        lat_check("afall", 1'b1, 1'b1, 1'b0, 1'b1);
        a_raw = 1'b1;
        lat_check("arise", 1'b0, 1'b1, 1'b1, 1'b1);
        chk("clean_glitch", 32'(glitch_count), 32'd0);

        // Both channels flip on the same edge.
        a_raw = 1'b0;
        b_raw = 1'b0;
        lat_check("both", 1'b1, 1'b1, 1'b0, 1'b0);

        // Concurrent 2-cycle pulses on both pins.
        a_raw = 1'b1;
        b_raw = 1'b1;
        repeat (2) tick();
        a_raw = 1'b0;
        b_raw = 1'b0;
        repeat (8) tick();
        chk("dual_a", 32'(a), 32'd0);
        chk("dual_b", 32'(b), 32'd0);
        chk("dual_glitch", 32'(glitch_count), 32'(gx(2)));

        // Bounce: 3-cycle pulse on A is one cycle short.
        a_raw = 1'b1;
        repeat (3) tick();
        a_raw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("bounce_a", 32'(a), 32'd0);
            chk("bounce_ach", 32'(a_changed), 32'd0);
        end
        chk("bounce_glitch", 32'(glitch_count), 32'(gx(3)));

        // Saturation of the 2-bit counter.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("sat_clear", 32'(glitch_count), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            a_raw = 1'b1;
            repeat (2) tick();
            a_raw = 1'b0;
            repeat (6) tick();
            chk("sat_step", 32'(glitch_count), 32'(gx((i > 3) ? 3 : i)));
        end
        repeat (10) tick();
        chk("sat_hold", 32'(glitch_count), 32'(gx(3)));
        chk("sat_a", 32'(a), 32'd0);

        // Reset in the middle of a count restarts the full latency.
        a_raw = 1'b1;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_a", 32'(a), 32'd0);
        chk("mid_rst_glitch", 32'(glitch_count), 32'd0);
        reset = 1'b0;
        lat_check("midrst", 1'b0, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
